// File: rtl/ctrl_spi_regs.sv
// ctrl_spi_regs: SPI-loaded shadow control registers with atomic commit to outputs
module ctrl_spi_regs #(
    parameter int NUM_CH = 8,
    parameter int BITS = 8,
    parameter int SYNC_STAGES = 2,
    parameter logic [BITS-1:0] RESET_VAL = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   CTRL_SCLK,
    input  logic                   CTRL_MOSI,
    input  logic                   CTRL_SS_n,
    output logic [NUM_CH*BITS-1:0] ctrl_out,
    output logic                   ctrl_upd,
    output logic                   wr_ack,
    output logic                   frame_err,
    output logic [7:0]             err_cnt
);
    localparam int FRAME_B = 4 + BITS;
    localparam int CW = $clog2(FRAME_B + 2);
    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;
    state_t state, state_nx;
    logic [SYNC_STAGES:0] sclk_s, mosi_s, ss_s;
    logic [FRAME_B-1:0] sr;
    logic [CW-1:0] cnt;
    logic [BITS-1:0] shadow [NUM_CH];
    logic sclk_rise, ss_rise, ss_fall, mosi_bit, len_ok;
    logic [3:0] addr;
    assign sclk_rise = sclk_s[SYNC_STAGES-1] & ~sclk_s[SYNC_STAGES];
    assign ss_rise = ss_s[SYNC_STAGES-1] & ~ss_s[SYNC_STAGES];
    assign ss_fall = ~ss_s[SYNC_STAGES-1] & ss_s[SYNC_STAGES];
    assign mosi_bit = mosi_s[SYNC_STAGES];
    assign addr = sr[FRAME_B-1 -: 4];
    assign len_ok = cnt == CW'(FRAME_B);
    // synchronisers plus edge-detect flop; zero reset hides a frame already in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_s <= '0;
            mosi_s <= '0;
            ss_s <= '0;
        end else begin
            sclk_s <= {sclk_s[SYNC_STAGES-1:0], CTRL_SCLK};
            mosi_s <= {mosi_s[SYNC_STAGES-1:0], CTRL_MOSI};
            ss_s <= {ss_s[SYNC_STAGES-1:0], CTRL_SS_n};
        end
    end
    // frame state register
    always_ff @(posedge clk) begin
        state <= reset ? IDLE : state_nx;
    end
    // next state: CHECK lasts one cycle unless a new frame starts right away
    always_comb begin
        state_nx = state;
        if (state == IDLE && ss_fall) state_nx = SHIFT;
        else if (state == SHIFT && ss_rise) state_nx = CHECK;
        else if (state == CHECK) state_nx = ss_fall ? SHIFT : IDLE;
    end
    // shifting, frame evaluation, shadow writes, commits and error counting
    always_ff @(posedge clk) begin
        if (reset) begin
            sr <= '0;
            cnt <= '0;
            for (int k = 0; k < NUM_CH; k++) shadow[k] <= RESET_VAL;
            ctrl_out <= {NUM_CH{RESET_VAL}};
            ctrl_upd <= 1'b0;
            wr_ack <= 1'b0;
            frame_err <= 1'b0;
            err_cnt <= '0;
        end else begin
            ctrl_upd <= 1'b0;
            wr_ack <= 1'b0;
            frame_err <= 1'b0;
            if (state_nx == SHIFT && state != SHIFT) begin
                sr <= '0;
                cnt <= '0;
            end else if (state == SHIFT && sclk_rise) begin
                sr <= {sr[FRAME_B-2:0], mosi_bit};
                if (cnt != CW'(FRAME_B + 1)) cnt <= cnt + CW'(1);
            end
            if (state == CHECK) begin
                if (len_ok && addr < 4'(NUM_CH)) begin
                    for (int k = 0; k < NUM_CH; k++)
                        if (addr == 4'(k)) shadow[k] <= sr[BITS-1:0];
                    wr_ack <= 1'b1;
                end else if (len_ok && addr == 4'hF) begin
                    for (int k = 0; k < NUM_CH; k++) ctrl_out[k*BITS +: BITS] <= shadow[k];
                    ctrl_upd <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                    if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ctrl_spi_regs.sv
// tb_ctrl_spi_regs: directed self-checking bench for ctrl_spi_regs
module tb_ctrl_spi_regs;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sclk = 1'b0;
    logic mosi = 1'b0;
    logic ss_n = 1'b1;
    logic [63:0] ctrl_out;
    logic ctrl_upd, wr_ack, frame_err;
    logic [7:0] err_cnt;
    int n_tests = 0;
    int n_fail = 0;
    int n_wr = 0;
    int n_upd = 0;
    int n_err = 0;
    int n_excl = 0;
    int b_wr, b_upd, b_err;

    ctrl_spi_regs dut (
        .clk(clk), .reset(reset), .CTRL_SCLK(sclk), .CTRL_MOSI(mosi), .CTRL_SS_n(ss_n),
        .ctrl_out(ctrl_out), .ctrl_upd(ctrl_upd), .wr_ack(wr_ack), .frame_err(frame_err),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // pulse counters and exclusivity monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (wr_ack) n_wr++;
        if (ctrl_upd) n_upd++;
        if (frame_err) n_err++;
        if (int'(wr_ack) + int'(ctrl_upd) + int'(frame_err) > 1) n_excl++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic snap();
        b_wr = n_wr;
        b_upd = n_upd;
        b_err = n_err;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = v[i];
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic frame(input logic [31:0] v, input int n);
        ss_n = 1'b0;
        repeat (4) @(negedge clk);
        send_bits(v, n);
        repeat (4) @(negedge clk);
        ss_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic b2b(input logic [11:0] a, input logic [11:0] b, input int gs, input int gl);
        ss_n = 1'b0;
        repeat (4) @(negedge clk);
        send_bits({20'd0, a}, 12);
        repeat (4) @(negedge clk);
        #(gs) ss_n = 1'b1;
        #(gl) ss_n = 1'b0;
        @(negedge clk);
        repeat (4) @(negedge clk);
        send_bits({20'd0, b}, 12);
        repeat (4) @(negedge clk);
        ss_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_out", ctrl_out, 64'h0);
        check("rst_cnt", {56'd0, err_cnt}, 64'h0);
        check("rst_pulse", {61'd0, ctrl_upd, wr_ack, frame_err}, 64'h0);
        repeat (10) @(negedge clk);
        check("rst_release_quiet", n_wr + n_upd + n_err, 0);

        snap();
        frame(32'h25A, 12);
        check("wr_ack", n_wr - b_wr, 1);
        check("wr_hold_out", ctrl_out, 64'h0);
        frame(32'hF00, 12);
        check("commit_upd", n_upd - b_upd, 1);
        check("commit_out", ctrl_out, 64'h0000_0000_005A_0000);

        snap();
        frame(32'h255, 11);
        frame(32'h0233, 13);
        check("len_err", n_err - b_err, 2);
        check("len_cnt", {56'd0, err_cnt}, 2);
        check("len_no_wr", n_wr - b_wr, 0);
        frame(32'hF00, 12);
        check("len_out", ctrl_out, 64'h0000_0000_005A_0000);

        snap();
        frame(32'h9AA, 12);
        check("addr_err", n_err - b_err, 1);
        check("addr_cnt", {56'd0, err_cnt}, 3);
        frame(32'hF00, 12);
        check("addr_out", ctrl_out, 64'h0000_0000_005A_0000);

        ss_n = 1'b0;
        repeat (4) @(negedge clk);
        send_bits(32'hF, 6);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_out", ctrl_out, 64'h0);
        check("mid_rst_cnt", {56'd0, err_cnt}, 0);
        check("mid_rst_pulse", {61'd0, ctrl_upd, wr_ack, frame_err}, 0);
        snap();
        send_bits(32'h3F, 6);
        repeat (4) @(negedge clk);
        ss_n = 1'b1;
        repeat (12) @(negedge clk);
        check("mid_rst_tail", (n_wr - b_wr) + (n_upd - b_upd) + (n_err - b_err), 0);
        check("mid_rst_tail_cnt", {56'd0, err_cnt}, 0);
        frame(32'h311, 12);
        frame(32'hF00, 12);
        check("post_rst_out", ctrl_out, 64'h0000_0000_1100_0000);

        snap();
        for (int i = 0; i < 300; i++) frame(32'h5, 3);
        check("sat_cnt", {56'd0, err_cnt}, 255);
        check("sat_pulses", n_err - b_err, 300);
        frame(32'h5, 3);
        check("sat_hold", {56'd0, err_cnt}, 255);

        snap();
        b2b(12'h4AB, 12'h5CD, 3, 6);
        check("b2b_split_wr", n_wr - b_wr, 2);
        check("b2b_split_err", n_err - b_err, 0);
        check("b2b_split_hold", ctrl_out, 64'h0000_0000_1100_0000);
        frame(32'hF00, 12);
        check("b2b_split_out", ctrl_out, 64'h0000_CDAB_1100_0000);

        snap();
        b2b(12'h477, 12'h588, 1, 3);
        check("b2b_merge_wr", n_wr - b_wr, 0);
        check("b2b_merge_err", n_err - b_err, 1);
        frame(32'hF00, 12);
        check("b2b_merge_out", ctrl_out, 64'h0000_CDAB_1100_0000);

        check("excl", n_excl, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
